level_alarm_controller: RTL and testbench
=========================================

Name: level_alarm_controller

Overview:
Sequencing and threshold controller for the 8-probe liquid level meter. Samples the thermometer-coded sensor bus at a fixed rate and converts it to a level of 0..8. Stores operator-set high/low thresholds captured from setup_input via the debounced saveH/saveL buttons. Runs the alarm state machine that drives the three status LEDs and feeds level/threshold values to the 7-segment display driver.

Parameters:
SAMPLE_DIV, 1_000_000, clk_100MHz cycles between sensor samples (10 ms); legal range >=2.
DEB_CYCLES, 500_000, cycles a synchronized button must be stable before it is accepted; legal range >=1.
PERSIST, 3, consecutive samples required for any state transition; legal range 1..15.
DEF_HIGH, 6, high threshold after reset.
DEF_LOW, 2, low threshold after reset.

Ports:
clk_100MHz  in  1  system clock, 100 MHz
reset_button  in  1  asynchronous reset, active-low
sensors_input  in  8  probe bus, bit0 = lowest probe, asynchronous to clock
setup_input  in  8  threshold setup switches, thermometer coded
saveH_button  in  1  raw button, capture high threshold
saveL_button  in  1  raw button, capture low threshold
level  out  4  current level 0..8, valid sample only
thr_high  out  4  stored high threshold
thr_low  out  4  stored low threshold
LED  out  3  [2]=high alarm, [1]=normal, [0]=low alarm
fault  out  1  sensor bus is in FAULT state
save_err  out  1  one-cycle pulse: a save request was rejected

Behaviour:
- Reset (reset_button=0): level=0, thr_high=DEF_HIGH, thr_low=DEF_LOW, state=NORMAL, LED=3'b010, fault=0, save_err=0; all counters and synchronizers are cleared.
- Inputs: sensors_input, setup_input and both buttons pass through 2-FF synchronizers before any use.
- Sample strobe: a free-running divider asserts the strobe for 1 cycle every SAMPLE_DIV cycles. The first strobe occurs SAMPLE_DIV cycles after reset deassertion.
- Validity: a sample is valid iff sync_sensors == (1<<n)-1 for some n in 0..8, giving level n.
- Level register: on a valid strobe, level<=n. On an invalid strobe, level holds.
- Debounce: each button has its own counter. The accepted value changes only after DEB_CYCLES identical synchronized cycles. A save fires on the accepted rising edge only; holding the button gives one save.
- Save value: the level of sync_setup under the same validity rule.
  - saveH is accepted iff setup is valid and value > thr_low; then thr_high<=value on the next edge.
  - saveL is accepted iff setup is valid and value < thr_high; then thr_low<=value.
  - A rejected save leaves the thresholds unchanged and pulses save_err for 1 cycle.
  - If saveH and saveL fire in the same cycle, saveH is processed and saveL is dropped (no save_err for the dropped saveL).
- States: NORMAL, HIGH, LOW, FAULT. Counters advance only on strobes. Each counter saturates at PERSIST and clears when its condition fails on a strobe. All counters clear on any state change.
  - NORMAL->HIGH: PERSIST consecutive valid samples with level>=thr_high.
  - NORMAL->LOW: PERSIST consecutive valid samples with level<=thr_low.
  - HIGH->NORMAL: PERSIST consecutive valid samples with level<thr_high.
  - LOW->NORMAL: PERSIST consecutive valid samples with level>thr_low.
  - HIGH<->LOW direct transition uses the corresponding entry condition, with the same PERSIST rule.
  - Any state->FAULT: PERSIST consecutive invalid samples. This has priority over all other transitions.
  - FAULT->NORMAL: PERSIST consecutive valid samples. After that, the normal entry rules apply again.
- Transition timing: a transition occurs at the clock edge of the strobe that completes the PERSIST-th qualifying sample.
- Outputs: LED and fault are a direct decode of the registered state, with no extra latency.
  - NORMAL=010, HIGH=100, LOW=001, FAULT=111 with fault=1.
- Threshold change mid-state: new thresholds apply from the next strobe. Counters are not cleared, and the state is not forced.
- Reset mid-operation: takes effect immediately (asynchronous), regardless of state, counters or debounce progress.

Test Plan:
All scenarios use SAMPLE_DIV=4, DEB_CYCLES=3, PERSIST=2.
1. Reset, then hold sensors=0000_0000 -> LED=010, thr_high=6, thr_low=2, level=0 after the first strobe, state stays NORMAL; 2 strobes with level<=2 -> LED=001 on the 2nd strobe edge.
2. setup=0111_1111, pulse saveH 10 cycles -> thr_high=7 and exactly one save, no save_err. Then setup=0000_1111, pulse saveL -> thr_low=4.
3. sensors=1111_1111 -> level=8 on the next strobe; LED=100 exactly at the 2nd strobe; sensors=0000_0111 -> LED=001 after 2 strobes via direct HIGH->LOW.
4. sensors=0001_1011 (invalid) for 2 strobes -> level holds its last value, fault=1, LED=111; then 0000_0111 for 2 strobes -> LED=010 (NORMAL), then LOW after 2 more strobes.
5. With thr_low=4: setup=0000_0011 saveH -> save_err pulse, thr_high unchanged. setup=0101_0000 saveL -> save_err. Simultaneous saveH(0111_1111)/saveL -> only thr_high=7 is updated.
6. Button bounce 1-0-1 at 1-cycle spacing -> no save. Assert reset_button=0 while in HIGH -> immediate LED=010, thresholds back to 6/2.

Source files
------------

// File: rtl/level_alarm_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// level_alarm_controller : probe sampling, threshold storage and alarm FSM
// Revision 1.0
// ---------------------------------------------------------------------------
module level_alarm_controller #(
  parameter int SAMPLE_DIV = 1_000_000,
  parameter int DEB_CYCLES = 500_000,
  parameter int PERSIST    = 3,
  parameter int DEF_HIGH   = 6,
  parameter int DEF_LOW    = 2
) (
  input  logic       clk_100MHz,
  input  logic       reset_button,
  input  logic [7:0] sensors_input,
  input  logic [7:0] setup_input,
  input  logic       saveH_button,
  input  logic       saveL_button,
  output logic [3:0] level,
  output logic [3:0] thr_high,
  output logic [3:0] thr_low,
  output logic [2:0] LED,
  output logic       fault,
  output logic       save_err
);

  localparam int         DIV_W     = $clog2(SAMPLE_DIV);
  localparam int         DEB_W     = $clog2(DEB_CYCLES + 1);
  localparam logic [3:0] PERSIST_C = 4'(PERSIST);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_HIGH   = 2'd1,
    ST_LOW    = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  // Returns {valid, level}; valid only for a contiguous run of ones from bit 0.
  function automatic logic [4:0] therm_decode(input logic [7:0] v);
    logic [4:0] r;
    r = 5'd0;
    for (int n = 0; n <= 8; n++) begin
      if ({1'b0, v} == ((9'd1 << n) - 9'd1)) r = {1'b1, 4'(n)};
    end
    return r;
  endfunction

  function automatic logic [3:0] bump(input logic [3:0] c, input logic cond);
    if (!cond) return 4'd0;
    if (c == PERSIST_C) return c;
    return c + 4'd1;
  endfunction

  logic [7:0] sens_s1, sens_s2, setup_s1, setup_s2;
  logic [1:0] btn_s1, btn_s2;

  always_ff @(posedge clk_100MHz or negedge reset_button) begin
    if (!reset_button) begin
      sens_s1  <= 8'd0;
      sens_s2  <= 8'd0;
      setup_s1 <= 8'd0;
      setup_s2 <= 8'd0;
      btn_s1   <= 2'd0;
      btn_s2   <= 2'd0;
    end else begin
      sens_s1  <= sensors_input;
      sens_s2  <= sens_s1;
      setup_s1 <= setup_input;
      setup_s2 <= setup_s1;
      btn_s1   <= {saveH_button, saveL_button};
      btn_s2   <= btn_s1;
    end
  end

  logic [DIV_W-1:0] div_cnt;
  logic             strobe;

  assign strobe = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk_100MHz or negedge reset_button) begin
    if (!reset_button)  div_cnt <= '0;
    else if (strobe)    div_cnt <= '0;
    else                div_cnt <= div_cnt + DIV_W'(1);
  end

  logic [4:0] sens_dec, setup_dec;
  logic       sens_valid, setup_valid;
  logic [3:0] sens_lvl, setup_lvl;

  assign sens_dec    = therm_decode(sens_s2);
  assign setup_dec   = therm_decode(setup_s2);
  assign sens_valid  = sens_dec[4];
  assign sens_lvl    = sens_dec[3:0];
  assign setup_valid = setup_dec[4];
  assign setup_lvl   = setup_dec[3:0];

  // Index 1 = saveH, index 0 = saveL; rise fires on the accepted 0->1 change.
  logic [1:0] btn_rise;

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_deb
      logic             acc;
      logic [DEB_W-1:0] cnt;
      logic             done;

      assign done        = (cnt == DEB_W'(DEB_CYCLES - 1));
      assign btn_rise[b] = btn_s2[b] & ~acc & done;

      always_ff @(posedge clk_100MHz or negedge reset_button) begin
        if (!reset_button) begin
          acc <= 1'b0;
          cnt <= '0;
        end else if (btn_s2[b] == acc) begin
          cnt <= '0;
        end else if (done) begin
          acc <= btn_s2[b];
          cnt <= '0;
        end else begin
          cnt <= cnt + DEB_W'(1);
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_100MHz or negedge reset_button) begin
    if (!reset_button) begin
      thr_high <= 4'(DEF_HIGH);
      thr_low  <= 4'(DEF_LOW);
      save_err <= 1'b0;
    end else begin
      save_err <= 1'b0;
      // saveH wins a same-cycle collision; the saveL request is silently dropped.
      if (btn_rise[1]) begin
        if (setup_valid && (setup_lvl > thr_low)) thr_high <= setup_lvl;
        else                                      save_err <= 1'b1;
      end else if (btn_rise[0]) begin
        if (setup_valid && (setup_lvl < thr_high)) thr_low <= setup_lvl;
        else                                       save_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset_button) begin
    if (!reset_button)              level <= 4'd0;
    else if (strobe && sens_valid)  level <= sens_lvl;
  end

  state_t     state, state_nx;
  logic [3:0] c_fault, c_high, c_low, c_norm;
  logic [3:0] c_fault_nx, c_high_nx, c_low_nx, c_norm_nx;
  logic       cond_high, cond_low, cond_norm;

  assign cond_high = sens_valid && (sens_lvl >= thr_high);
  assign cond_low  = sens_valid && (sens_lvl <= thr_low);

  always_ff @(posedge clk_100MHz or negedge reset_button) begin
    if (!reset_button) begin
      state   <= ST_NORMAL;
      c_fault <= 4'd0;
      c_high  <= 4'd0;
      c_low   <= 4'd0;
      c_norm  <= 4'd0;
    end else begin
      state   <= state_nx;
      c_fault <= c_fault_nx;
      c_high  <= c_high_nx;
      c_low   <= c_low_nx;
      c_norm  <= c_norm_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    c_fault_nx = c_fault;
    c_high_nx  = c_high;
    c_low_nx   = c_low;
    c_norm_nx  = c_norm;
    cond_norm  = 1'b0;

    // c_norm tracks the exit condition that belongs to the current state.
    case (state)
      ST_HIGH:  cond_norm = sens_valid && (sens_lvl < thr_high);
      ST_LOW:   cond_norm = sens_valid && (sens_lvl > thr_low);
      ST_FAULT: cond_norm = sens_valid;
      default:  cond_norm = 1'b0;
    endcase

    if (strobe) begin
      c_fault_nx = bump(c_fault, !sens_valid);
      c_high_nx  = bump(c_high, cond_high);
      c_low_nx   = bump(c_low, cond_low);
      c_norm_nx  = bump(c_norm, cond_norm);

      if ((c_fault_nx == PERSIST_C) && (state != ST_FAULT)) begin
        state_nx = ST_FAULT;
      end else begin
        // Direct HIGH<->LOW entry takes precedence over the return to NORMAL.
        case (state)
          ST_NORMAL: begin
            if (c_high_nx == PERSIST_C)     state_nx = ST_HIGH;
            else if (c_low_nx == PERSIST_C) state_nx = ST_LOW;
          end
          ST_HIGH: begin
            if (c_low_nx == PERSIST_C)       state_nx = ST_LOW;
            else if (c_norm_nx == PERSIST_C) state_nx = ST_NORMAL;
          end
          ST_LOW: begin
            if (c_high_nx == PERSIST_C)      state_nx = ST_HIGH;
            else if (c_norm_nx == PERSIST_C) state_nx = ST_NORMAL;
          end
          default: begin
            if (c_norm_nx == PERSIST_C)      state_nx = ST_NORMAL;
          end
        endcase
      end

      if (state_nx != state) begin
        c_fault_nx = 4'd0;
        c_high_nx  = 4'd0;
        c_low_nx   = 4'd0;
        c_norm_nx  = 4'd0;
      end
    end
  end

  always_comb begin
    LED   = 3'b010;
    fault = 1'b0;
    case (state)
      ST_HIGH:  LED = 3'b100;
      ST_LOW:   LED = 3'b001;
      ST_FAULT: begin
        LED   = 3'b111;
        fault = 1'b1;
      end
      default:  LED = 3'b010;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_level_alarm_controller.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_level_alarm_controller : directed vector bench for level_alarm_controller
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_level_alarm_controller;

  logic       clk = 1'b0;
  logic       reset_button = 1'b1;
  logic [7:0] sensors_input = 8'd0;
  logic [7:0] setup_input = 8'd0;
  logic       saveH_button = 1'b0;
  logic       saveL_button = 1'b0;
  logic [3:0] level, thr_high, thr_low;
  logic [2:0] LED;
  logic       fault, save_err;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  level_alarm_controller #(
    .SAMPLE_DIV(4),
    .DEB_CYCLES(3),
    .PERSIST(2),
    .DEF_HIGH(6),
    .DEF_LOW(2)
  ) dut (
    .clk_100MHz(clk),
    .reset_button(reset_button),
    .sensors_input(sensors_input),
    .setup_input(setup_input),
    .saveH_button(saveH_button),
    .saveL_button(saveL_button),
    .level(level),
    .thr_high(thr_high),
    .thr_low(thr_low),
    .LED(LED),
    .fault(fault),
    .save_err(save_err)
  );

  // Cycles since reset release; sample strobes land on edges where cyc % 4 == 0.
  always @(posedge clk or negedge reset_button) begin
    if (!reset_button) cyc <= 0;
    else               cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (save_err) err_cnt = err_cnt + 1;
  end

  typedef struct {
    logic [7:0] sens;
    logic [3:0] lvl;
    logic [2:0] led;
  } vec_t;

  vec_t vecs [0:15];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests = tests + 1;
    if (act !== exp) begin
      fails = fails + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic to_strobe();
    do begin
      @(posedge clk);
      #1;
    end while (cyc % 4 != 0);
  endtask

  task automatic press(input logic h, input logic l, input int hold);
    saveH_button = h;
    saveL_button = l;
    repeat (hold) @(posedge clk);
    #1;
    saveH_button = 1'b0;
    saveL_button = 1'b0;
    repeat (12) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    vecs[0]  = '{8'hFF, 4'd8, 3'b001};
    vecs[1]  = '{8'hFF, 4'd8, 3'b100};
    vecs[2]  = '{8'h07, 4'd3, 3'b100};
    vecs[3]  = '{8'h07, 4'd3, 3'b001};
    vecs[4]  = '{8'h1B, 4'd3, 3'b001};
    vecs[5]  = '{8'h1B, 4'd3, 3'b111};
    vecs[6]  = '{8'h07, 4'd3, 3'b111};
    vecs[7]  = '{8'h07, 4'd3, 3'b010};
    vecs[8]  = '{8'h07, 4'd3, 3'b010};
    vecs[9]  = '{8'h07, 4'd3, 3'b001};
    vecs[10] = '{8'h1F, 4'd5, 3'b001};
    vecs[11] = '{8'h1F, 4'd5, 3'b010};
    vecs[12] = '{8'hFF, 4'd8, 3'b010};
    vecs[13] = '{8'h1F, 4'd5, 3'b010};
    vecs[14] = '{8'hFF, 4'd8, 3'b010};
    vecs[15] = '{8'hFF, 4'd8, 3'b100};

    // Reset state
    #2 reset_button = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_led", 8'(LED), 8'h02);
    check("rst_thr_high", 8'(thr_high), 8'd6);
    check("rst_thr_low", 8'(thr_low), 8'd2);
    check("rst_level", 8'(level), 8'd0);
    check("rst_fault", 8'(fault), 8'd0);
    check("rst_save_err", 8'(save_err), 8'd0);
    @(negedge clk) reset_button = 1'b1;

    // Empty tank: NORMAL after first strobe, LOW at the second
    to_strobe();
    check("s1_level", 8'(level), 8'd0);
    check("s1_led", 8'(LED), 8'h02);
    to_strobe();
    check("s2_led_low", 8'(LED), 8'h01);

    // Threshold setup
    e0 = err_cnt;
    setup_input = 8'b0111_1111;
    press(1'b1, 1'b0, 10);
    check("saveH_thr_high", 8'(thr_high), 8'd7);
    check("saveH_no_err", 8'(err_cnt - e0), 8'd0);
    setup_input = 8'b0000_1111;
    press(1'b0, 1'b1, 10);
    check("saveL_thr_low", 8'(thr_low), 8'd4);
    check("saveL_no_err", 8'(err_cnt - e0), 8'd0);

    // Sampled level / state sequence
    to_strobe();
    for (int i = 0; i < 16; i++) begin
      sensors_input = vecs[i].sens;
      to_strobe();
      check($sformatf("vec%0d_level", i), 8'(level), 8'(vecs[i].lvl));
      check($sformatf("vec%0d_led", i), 8'(LED), 8'(vecs[i].led));
      check($sformatf("vec%0d_fault", i), 8'(fault), 8'(vecs[i].led == 3'b111));
    end

    // Rejected saves with thr_low=4, thr_high=7
    e0 = err_cnt;
    setup_input = 8'b0000_0011;
    press(1'b1, 1'b0, 8);
    check("rejH_thr_high", 8'(thr_high), 8'd7);
    check("rejH_err", 8'(err_cnt - e0), 8'd1);
    e0 = err_cnt;
    setup_input = 8'b0101_0000;
    press(1'b0, 1'b1, 8);
    check("rejL_thr_low", 8'(thr_low), 8'd4);
    check("rejL_err", 8'(err_cnt - e0), 8'd1);

    e0 = err_cnt;
    setup_input = 8'b0011_1111;
    press(1'b1, 1'b0, 8);
    check("setH6_thr_high", 8'(thr_high), 8'd6);
    setup_input = 8'b0111_1111;
    press(1'b1, 1'b1, 8);
    check("both_thr_high", 8'(thr_high), 8'd7);
    check("both_thr_low", 8'(thr_low), 8'd4);
    check("both_no_err", 8'(err_cnt - e0), 8'd0);

    // Bounce 1-0-1 at one-cycle spacing must not save
    e0 = err_cnt;
    setup_input = 8'b0011_1111;
    saveH_button = 1'b1;
    @(posedge clk); #1;
    saveH_button = 1'b0;
    @(posedge clk); #1;
    saveH_button = 1'b1;
    @(posedge clk); #1;
    saveH_button = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("bounce_thr_high", 8'(thr_high), 8'd7);
    check("bounce_no_err", 8'(err_cnt - e0), 8'd0);
    check("pre_reset_high", 8'(LED), 8'h04);

    // Asynchronous reset while in HIGH
    #3 reset_button = 1'b0;
    #1;
    check("async_rst_led", 8'(LED), 8'h02);
    check("async_rst_thr_high", 8'(thr_high), 8'd6);
    check("async_rst_thr_low", 8'(thr_low), 8'd2);
    check("async_rst_level", 8'(level), 8'd0);
    check("async_rst_fault", 8'(fault), 8'd0);
    @(negedge clk) reset_button = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_led", 8'(LED), 8'h02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
